// File: rtl/sd_wb32_byte_bridge_if.sv
// sd_wb32_byte_bridge_if: Wishbone 32-bit slave side (wb_*) plus 8-bit register bus (reg_*); slave modport faces the bridge
interface sd_wb32_byte_bridge_if #(parameter int ADDR_W = 7);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, reg_rdata,
    output wb_dat_o, wb_ack_o, reg_we, reg_addr, reg_wdata
  );
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, reg_rdata,
    input  wb_dat_o, wb_ack_o, reg_we, reg_addr, reg_wdata
  );
endinterface

// File: rtl/sd_wb32_byte_bridge.sv
// sd_wb32_byte_bridge: splits 32-bit Wishbone cycles into four byte accesses (lane 3 first); ports clk, rst (async high), bus (wb_* slave, reg_* byte bus)
module sd_wb32_byte_bridge #(
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  sd_wb32_byte_bridge_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-3:0] word_q, word_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              lane_en;
  logic              unused_adr;
  assign unused_adr = ^bus.wb_adr_i[1:0];
  assign cur_addr = {word_q, cnt_q};
  assign lane_en  = sel_q[cnt_q];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    word_d  = word_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    if (state_q == IDLE && bus.wb_cyc_i && bus.wb_stb_i) begin
      state_d = XFER;
      we_d    = bus.wb_we_i;
      word_d  = bus.wb_adr_i[ADDR_W-1:2];
      sel_d   = bus.wb_sel_i;
      dat_d   = bus.wb_dat_i;
      rd_d    = '0;
      cnt_d   = 2'd3;
    end
    if (state_q == XFER) begin
      addr_d = cur_addr;
      cnt_d  = cnt_q - 2'd1;
      if (!we_q && lane_en) rd_d[8*cnt_q +: 8] = bus.reg_rdata;
      if (cnt_q == 2'd0) state_d = ACK;
    end
    if (state_q == ACK) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd3;
      we_q    <= 1'b0;
      word_q  <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
    end
  end
  // Byte-bus outputs decode from registered state only; addr_q keeps the last lane address outside XFER.
  assign bus.reg_we    = (state_q == XFER) && we_q && lane_en;
  assign bus.reg_addr  = (state_q == XFER) ? cur_addr : addr_q;
  assign bus.reg_wdata = bus.reg_we ? dat_q[8*cnt_q +: 8] : 8'h00;
  assign bus.wb_ack_o  = (state_q == ACK) && bus.wb_cyc_i;
  assign bus.wb_dat_o  = (state_q == ACK && !we_q) ? rd_q : 32'h0;
endmodule

// File: tb/tb_sd_wb32_byte_bridge.sv
// tb_sd_wb32_byte_bridge: randomized and directed checks of the byte bridge against a transaction-level model
module tb_sd_wb32_byte_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sd_wb32_byte_bridge_if #(.ADDR_W(7)) bus();
  sd_wb32_byte_bridge #(.ADDR_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int bad_wd = 0;
  int st_rd = 0;
  int ack_rd = 0;
  bit mode = 1'b0;
  logic [7:0]  mem [128];
  logic [47:0] st_log[$];
  logic [47:0] st_exp[$];
  logic [63:0] ack_log[$];
  logic [63:0] ack_exp[$];
  assign bus.reg_rdata = mode ? 8'({1'b0, bus.reg_addr} + 8'h40) : mem[bus.reg_addr];
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
  end
  always @(negedge clk) begin
    if (bus.reg_we) st_log.push_back({32'(cyc_n), 1'b0, bus.reg_addr, bus.reg_wdata});
    else if (bus.reg_wdata != 8'h00) bad_wd++;
    if (bus.wb_ack_o) ack_log.push_back({32'(cyc_n), bus.wb_dat_o});
  end
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Model: lane l of an access accepted so that its first lane cycle is `start` runs in cycle start+3-l; ack in start+4.
  task automatic expect_acc(bit we, logic [6:0] adr, logic [3:0] sel, logic [31:0] dat, int start, bit ack);
    logic [31:0] rd;
    rd = 32'h0;
    for (int l = 3; l >= 0; l--) begin
      logic [6:0] a;
      a = {adr[6:2], l[1:0]};
      if (sel[l]) begin
        if (we) st_exp.push_back({32'(start + 3 - l), 1'b0, a, dat[8*l +: 8]});
        else rd[8*l +: 8] = mode ? 8'({1'b0, a} + 8'h40) : mem[a];
      end
    end
    if (ack) ack_exp.push_back({32'(start + 4), we ? 32'h0 : rd});
  endtask
  task automatic compare_logs(string tag);
    chk({tag, "_nstb"}, 64'(st_log.size() - st_rd), 64'(st_exp.size()));
    for (int i = 0; i < st_exp.size(); i++)
      if (st_rd + i < st_log.size()) chk({tag, "_stb"}, 64'(st_log[st_rd + i]), 64'(st_exp[i]));
    st_rd = st_log.size();
    st_exp.delete();
    chk({tag, "_nack"}, 64'(ack_log.size() - ack_rd), 64'(ack_exp.size()));
    for (int i = 0; i < ack_exp.size(); i++)
      if (ack_rd + i < ack_log.size()) chk({tag, "_ack"}, ack_log[ack_rd + i], ack_exp[i]);
    ack_rd = ack_log.size();
    ack_exp.delete();
  endtask
  task automatic drive(bit we, logic [6:0] adr, logic [3:0] sel, logic [31:0] dat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
  endtask
  task automatic wait_ack(string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 10);
    if (!bus.wb_ack_o) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask
  task automatic release_bus();
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
  endtask
  task automatic run(string tag, bit we, logic [6:0] adr, logic [3:0] sel, logic [31:0] dat);
    expect_acc(we, adr, sel, dat, cyc_n + 1, 1'b1);
    drive(we, adr, sel, dat);
    wait_ack(tag);
    release_bus();
    compare_logs(tag);
  endtask
  initial begin
    int start;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(bus.wb_ack_o), 64'd0);
    chk("rst_dat", 64'(bus.wb_dat_o), 64'd0);
    chk("rst_we", 64'(bus.reg_we), 64'd0);
    chk("rst_addr", 64'(bus.reg_addr), 64'd0);
    chk("rst_wdata", 64'(bus.reg_wdata), 64'd0);
    rst = 1'b0;
    run("wr_full", 1'b1, 7'h00, 4'hF, 32'h12345678);
    run("rd_full", 1'b0, 7'h00, 4'hF, 32'h0);
    run("wr_lane1", 1'b1, 7'h2C, 4'b0010, 32'hAABBCCDD);
    mode = 1'b1;
    run("rd_sparse", 1'b0, 7'h08, 4'b1001, 32'h0);
    mode = 1'b0;
    start = cyc_n + 1;
    expect_acc(1'b1, 7'h20, 4'hF, 32'hCAFEF00D, start, 1'b0);
    drive(1'b1, 7'h20, 4'hF, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (7) @(negedge clk);
    compare_logs("cyc_drop");
    run("rd_after_drop", 1'b0, 7'h00, 4'hF, 32'h0);
    run("rd_dropped", 1'b0, 7'h20, 4'hF, 32'h0);
    start = cyc_n + 1;
    expect_acc(1'b1, 7'h10, 4'b1100, 32'h11223344, start, 1'b0);
    drive(1'b1, 7'h10, 4'hF, 32'h11223344);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    #1;
    chk("arst_we", 64'(bus.reg_we), 64'd0);
    chk("arst_ack", 64'(bus.wb_ack_o), 64'd0);
    chk("arst_addr", 64'(bus.reg_addr), 64'd0);
    chk("arst_wdata", 64'(bus.reg_wdata), 64'd0);
    chk("arst_dat", 64'(bus.wb_dat_o), 64'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    compare_logs("arst");
    run("wr_after_rst", 1'b1, 7'h10, 4'hF, 32'h55667788);
    run("rd_after_rst", 1'b0, 7'h10, 4'hF, 32'h0);
    start = cyc_n + 1;
    expect_acc(1'b1, 7'h30, 4'hF, 32'hA1B2C3D4, start, 1'b1);
    expect_acc(1'b1, 7'h30, 4'hF, 32'h0F1E2D3C, start + 6, 1'b1);
    drive(1'b1, 7'h30, 4'hF, 32'hA1B2C3D4);
    wait_ack("b2b_first");
    bus.wb_dat_i = 32'h0F1E2D3C;
    @(negedge clk);
    wait_ack("b2b_second");
    release_bus();
    compare_logs("b2b");
    for (int t = 0; t < 30; t++) begin
      bit we;
      logic [6:0] adr;
      logic [3:0] sel;
      logic [31:0] dat;
      we   = 1'($urandom);
      adr  = 7'($urandom_range(0, 127));
      sel  = 4'($urandom);
      dat  = $urandom;
      mode = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run("rand", we, adr, sel, dat);
    end
    chk("wdata_idle_zero", 64'(bad_wd), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
